// File: rtl/ex_mem_req.sv
// EX-stage data-SRAM request issuer: turns ld/st ops into req/addr_ok handshakes,
// stalls EX until the address phase completes and marks data_ok returns owed to flushed requests.
module ex_mem_req #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [4:0]  ex_ld_op,
  input  logic [2:0]  ex_st_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_st_data,
  input  logic        ex_exc_in,
  input  logic        flush,
  input  logic        mem_allow_in,
  output logic        ex_ready_go,
  output logic        ale,
  output logic        wait_data_ok,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        data_ok_discard,
  output logic [1:0]  state_dbg
);

  // Handshake: a request is accepted in any cycle where data_sram_req and
  // data_sram_addr_ok are both high; once raised, req and every request field
  // stay stable until that cycle. data_ok returns one per accepted request, in order.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t state, state_next;

  logic             cancel, cancel_next;
  logic [CNT_W-1:0] inflight, inflight_next;
  logic [CNT_W-1:0] discard_cnt;

  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [3:0]  lat_wstrb;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        mem_op, is_word, is_half, start, accept, advance, latch_en;
  logic        ex_wr;
  logic [1:0]  ex_size;
  logic [3:0]  ex_wstrb;
  logic [31:0] ex_wdata;

  // Op decode: ld {w,b,bu,h,hu}, st {w,h,b}
  assign mem_op  = (|ex_ld_op) | (|ex_st_op);
  assign is_word = ex_ld_op[4] | ex_st_op[2];
  assign is_half = ex_ld_op[1] | ex_ld_op[0] | ex_st_op[1];
  assign ex_wr   = |ex_st_op;
  assign ex_size = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);

  assign ale = ex_valid & ((is_half & ex_addr[0]) | (is_word & (|ex_addr[1:0])));

  always_comb begin
    ex_wstrb = 4'b0000;
    ex_wdata = ex_st_data;
    if (ex_st_op[0]) begin
      ex_wstrb = 4'b0001 << ex_addr[1:0];
      ex_wdata = {4{ex_st_data[7:0]}};
    end else if (ex_st_op[1]) begin
      ex_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
      ex_wdata = {2{ex_st_data[15:0]}};
    end else if (ex_st_op[2]) begin
      ex_wstrb = 4'b1111;
    end
  end

  assign start = ex_valid & mem_op & ~ale & ~ex_exc_in & ~flush & (discard_cnt == '0);

  assign data_sram_req   = (state == S_IDLE) ? start : (state == S_REQ);
  assign data_sram_wr    = (state == S_IDLE) ? ex_wr    : lat_wr;
  assign data_sram_size  = (state == S_IDLE) ? ex_size  : lat_size;
  assign data_sram_wstrb = (state == S_IDLE) ? ex_wstrb : lat_wstrb;
  assign data_sram_addr  = (state == S_IDLE) ? ex_addr  : lat_addr;
  assign data_sram_wdata = (state == S_IDLE) ? ex_wdata : lat_wdata;

  assign accept  = data_sram_req & data_sram_addr_ok;
  assign ex_ready_go = ~ex_valid | ~mem_op | ale | ex_exc_in | (state == S_ACC) | (accept & ~cancel);
  assign advance = ex_ready_go & mem_allow_in;

  assign wait_data_ok = ex_valid & mem_op & ~ale & ~ex_exc_in
                      & ((state == S_ACC) | accept) & ~cancel;

  assign data_ok_discard = data_sram_data_ok & (discard_cnt != '0);
  assign state_dbg       = state;

  always_comb begin
    state_next  = state;
    cancel_next = cancel;
    latch_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (data_sram_addr_ok) begin
            state_next = advance ? S_IDLE : S_ACC;
          end else begin
            state_next = S_REQ;
            latch_en   = 1'b1;
          end
        end
      end
      S_REQ: begin
        // The interconnect may already hold the request, so a flush only marks it cancelled.
        if (data_sram_addr_ok) begin
          state_next  = (cancel | flush | advance) ? S_IDLE : S_ACC;
          cancel_next = 1'b0;
        end else if (flush) begin
          cancel_next = 1'b1;
        end
      end
      S_ACC: begin
        if (advance | flush) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign inflight_next = inflight + CNT_W'(accept) - CNT_W'(data_sram_data_ok);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cancel      <= 1'b0;
      inflight    <= '0;
      discard_cnt <= '0;
      lat_wr      <= 1'b0;
      lat_size    <= 2'd0;
      lat_wstrb   <= 4'd0;
      lat_addr    <= 32'd0;
      lat_wdata   <= 32'd0;
    end else begin
      state    <= state_next;
      cancel   <= cancel_next;
      inflight <= inflight_next;
      // On flush every request still owed a data_ok (after this cycle's traffic) is dropped.
      if (flush) begin
        discard_cnt <= inflight_next;
      end else begin
        discard_cnt <= discard_cnt + CNT_W'(cancel & accept) - CNT_W'(data_ok_discard);
      end
      if (latch_en) begin
        lat_wr    <= ex_wr;
        lat_size  <= ex_size;
        lat_wstrb <= ex_wstrb;
        lat_addr  <= ex_addr;
        lat_wdata <= ex_wdata;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_req.sv
// Directed bench for ex_mem_req: stimulus pushes expected requests / data_ok tags,
// a negedge monitor pops and compares whenever the DUT accepts or returns.
module tb_ex_mem_req;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [4:0]  ex_ld_op;
  logic [2:0]  ex_st_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_st_data;
  logic        ex_exc_in;
  logic        flush;
  logic        mem_allow_in;
  logic        ex_ready_go;
  logic        ale;
  logic        wait_data_ok;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic        data_ok_discard;
  logic [1:0]  state_dbg;

  localparam logic [4:0] LD_W  = 5'b10000;
  localparam logic [4:0] LD_B  = 5'b01000;
  localparam logic [4:0] LD_H  = 5'b00010;
  localparam logic [4:0] LD_HU = 5'b00001;
  localparam logic [2:0] ST_W  = 3'b100;
  localparam logic [2:0] ST_H  = 3'b010;
  localparam logic [2:0] ST_B  = 3'b001;

  // Packet: {wr, size, wstrb, addr, wdata}; wdata is zero for loads.
  logic [70:0] exp_q[$];
  logic [0:0]  dok_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles;

  ex_mem_req #(.CNT_W(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_valid          (ex_valid),
    .ex_ld_op          (ex_ld_op),
    .ex_st_op          (ex_st_op),
    .ex_addr           (ex_addr),
    .ex_st_data        (ex_st_data),
    .ex_exc_in         (ex_exc_in),
    .flush             (flush),
    .mem_allow_in      (mem_allow_in),
    .ex_ready_go       (ex_ready_go),
    .ale               (ale),
    .wait_data_ok      (wait_data_ok),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_ok_discard   (data_ok_discard),
    .state_dbg         (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ex_valid          = 1'b0;
    ex_ld_op          = 5'd0;
    ex_st_op          = 3'd0;
    ex_addr           = 32'd0;
    ex_st_data        = 32'd0;
    ex_exc_in         = 1'b0;
    flush             = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic issue(input logic [4:0] ld, input logic [2:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    ex_valid   = 1'b1;
    ex_ld_op   = ld;
    ex_st_op   = st;
    ex_addr    = a;
    ex_st_data = d;
  endtask

  task automatic exp_req(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                         input logic [31:0] a, input logic [31:0] wd);
    exp_q.push_back({wr, size, wstrb, a, wd});
  endtask

  // One data_ok cycle; caller is just after a posedge.
  task automatic retire(input logic disc);
    data_sram_data_ok = 1'b1;
    dok_q.push_back(disc);
    at_neg();
    step();
    data_sram_data_ok = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (data_sram_req && data_sram_addr_ok) begin
        logic [70:0] act, exp;
        act = {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr,
               data_sram_wr ? data_sram_wdata : 32'd0};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL req_accept: unexpected request got %0h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_fail++;
            $display("FAIL req_accept: got %0h expected %0h", act, exp);
          end
        end
      end
      if (data_sram_data_ok) begin
        n_checks++;
        if (dok_q.size() == 0) begin
          n_fail++;
          $display("FAIL data_ok_tag: unexpected data_ok got %0b expected none", data_ok_discard);
        end else begin
          logic [0:0] e;
          e = dok_q.pop_front();
          if (data_ok_discard !== e) begin
            n_fail++;
            $display("FAIL data_ok_tag: got %0b expected %0b", data_ok_discard, e);
          end
        end
      end
    end
  end

  initial begin
    drive_idle();
    mem_allow_in = 1'b1;
    resetn       = 1'b0;
    repeat (2) step();
    at_neg();
    check("rst_req",     {31'd0, data_sram_req},   32'd0);
    check("rst_wait",    {31'd0, wait_data_ok},    32'd0);
    check("rst_discard", {31'd0, data_ok_discard}, 32'd0);
    check("rst_ready",   {31'd0, ex_ready_go},     32'd1);
    check("rst_state",   {30'd0, state_dbg},       32'd0);
    step();
    resetn = 1'b1;
    step();

    // ld_w accepted in the issue cycle
    issue(LD_W, 3'd0, 32'h1000, 32'd0);
    data_sram_addr_ok = 1'b1;
    exp_req(1'b0, 2'd2, 4'b0000, 32'h1000, 32'd0);
    at_neg();
    check("ldw_req",   {31'd0, data_sram_req}, 32'd1);
    check("ldw_ready", {31'd0, ex_ready_go},   32'd1);
    check("ldw_wait",  {31'd0, wait_data_ok},  32'd1);
    step();
    drive_idle();
    check("ldw_state", {30'd0, state_dbg}, 32'd0);
    retire(1'b0);

    // st_b held for 3 cycles before addr_ok
    issue(3'd0 == 3'd0 ? 5'd0 : 5'd0, ST_B, 32'h1003, 32'h123456AB);
    exp_req(1'b1, 2'd0, 4'b1000, 32'h1003, 32'hABABABAB);
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      if (data_sram_req) req_cycles++;
      check("stb_stall", {31'd0, ex_ready_go}, 32'd0);
      check("stb_wdata", data_sram_wdata, 32'hABABABAB);
      check("stb_wstrb", {28'd0, data_sram_wstrb}, 32'h8);
      check("stb_addr",  data_sram_addr, 32'h1003);
      if (i > 0) check("stb_state", {30'd0, state_dbg}, 32'd1);
      step();
    end
    data_sram_addr_ok = 1'b1;
    at_neg();
    if (data_sram_req) req_cycles++;
    check("stb_ready", {31'd0, ex_ready_go}, 32'd1);
    step();
    drive_idle();
    check("stb_req_cycles", req_cycles, 32'd4);
    retire(1'b0);

    // misaligned accesses
    issue(LD_H, 3'd0, 32'h1001, 32'd0);
    data_sram_addr_ok = 1'b1;
    at_neg();
    check("ldh_ale",   {31'd0, ale},           32'd1);
    check("ldh_req",   {31'd0, data_sram_req}, 32'd0);
    check("ldh_ready", {31'd0, ex_ready_go},   32'd1);
    check("ldh_wait",  {31'd0, wait_data_ok},  32'd0);
    step();
    issue(5'd0, ST_W, 32'h1006, 32'd0);
    at_neg();
    check("stw_ale", {31'd0, ale}, 32'd1);
    step();
    drive_idle();

    // ld_hu accepted while MEM is blocked: hold in ACC
    issue(LD_HU, 3'd0, 32'h1002, 32'd0);
    mem_allow_in      = 1'b0;
    data_sram_addr_ok = 1'b1;
    exp_req(1'b0, 2'd1, 4'b0000, 32'h1002, 32'd0);
    at_neg();
    check("acc_ready0", {31'd0, ex_ready_go},  32'd1);
    check("acc_wait0",  {31'd0, wait_data_ok}, 32'd1);
    step();
    for (int i = 0; i < 2; i++) begin
      at_neg();
      check("acc_req",   {31'd0, data_sram_req}, 32'd0);
      check("acc_wait",  {31'd0, wait_data_ok},  32'd1);
      check("acc_state", {30'd0, state_dbg},     32'd2);
      step();
    end
    mem_allow_in = 1'b1;
    at_neg();
    check("acc_ready", {31'd0, ex_ready_go}, 32'd1);
    step();
    drive_idle();
    retire(1'b0);

    // st_h upper half
    issue(5'd0, ST_H, 32'h1006, 32'h0000BEEF);
    data_sram_addr_ok = 1'b1;
    exp_req(1'b1, 2'd1, 4'b1100, 32'h1006, 32'hBEEFBEEF);
    at_neg();
    check("sth_wait", {31'd0, wait_data_ok}, 32'd1);
    step();
    drive_idle();
    retire(1'b0);

    // flush while in REQ: request stays up, its data_ok is discarded
    issue(LD_B, 3'd0, 32'h2001, 32'd0);
    exp_req(1'b0, 2'd0, 4'b0000, 32'h2001, 32'd0);
    at_neg();
    check("fl_req0", {31'd0, data_sram_req}, 32'd1);
    step();
    drive_idle();
    flush = 1'b1;
    at_neg();
    check("fl_req_held", {31'd0, data_sram_req}, 32'd1);
    step();
    flush = 1'b0;
    at_neg();
    check("fl_req_after", {31'd0, data_sram_req}, 32'd1);
    check("fl_state",     {30'd0, state_dbg},     32'd1);
    step();
    data_sram_addr_ok = 1'b1;
    at_neg();
    step();
    issue(LD_W, 3'd0, 32'h3000, 32'd0);
    data_sram_data_ok = 1'b1;
    dok_q.push_back(1'b1);
    at_neg();
    check("fl_blocked_req",   {31'd0, data_sram_req}, 32'd0);
    check("fl_blocked_ready", {31'd0, ex_ready_go},   32'd0);
    step();
    data_sram_data_ok = 1'b0;
    exp_req(1'b0, 2'd2, 4'b0000, 32'h3000, 32'd0);
    at_neg();
    check("fl_resume_req",   {31'd0, data_sram_req}, 32'd1);
    check("fl_resume_ready", {31'd0, ex_ready_go},   32'd1);
    step();
    drive_idle();
    retire(1'b0);

    // two accepted loads in flight, then flush
    issue(LD_W, 3'd0, 32'h4000, 32'd0);
    data_sram_addr_ok = 1'b1;
    exp_req(1'b0, 2'd2, 4'b0000, 32'h4000, 32'd0);
    at_neg();
    step();
    issue(LD_W, 3'd0, 32'h4004, 32'd0);
    exp_req(1'b0, 2'd2, 4'b0000, 32'h4004, 32'd0);
    at_neg();
    step();
    drive_idle();
    flush = 1'b1;
    at_neg();
    check("f2_no_discard", {31'd0, data_ok_discard}, 32'd0);
    step();
    flush = 1'b0;
    issue(LD_W, 3'd0, 32'h5000, 32'd0);
    data_sram_addr_ok = 1'b1;
    data_sram_data_ok = 1'b1;
    dok_q.push_back(1'b1);
    at_neg();
    check("f2_blocked1", {31'd0, data_sram_req}, 32'd0);
    step();
    dok_q.push_back(1'b1);
    at_neg();
    check("f2_blocked2", {31'd0, data_sram_req}, 32'd0);
    step();
    data_sram_data_ok = 1'b0;
    exp_req(1'b0, 2'd2, 4'b0000, 32'h5000, 32'd0);
    at_neg();
    check("f2_resume", {31'd0, data_sram_req}, 32'd1);
    step();
    drive_idle();
    retire(1'b0);

    repeat (2) step();
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("dok_q_empty", dok_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
